// File: rtl/sa_inst_issue_if.sv
// rtl/sa_inst_issue_if.sv - instruction word type and host/issue handshake interface for sa_inst_issue
package sa_inst_pkg;
  typedef logic [31:0] sa_inst_t;
endpackage

interface sa_inst_issue_if;
  import sa_inst_pkg::*;

  logic     hvalid;
  logic     hready;
  sa_inst_t hinst;
  sa_inst_t inst;
  logic     iavail;
  logic     ird;

  // slave is the queue; master is the host producer plus the vinst_ctl consumer
  modport slave (input hvalid, hinst, ird, output hready, inst, iavail);
  modport master(output hvalid, hinst, ird, input hready, inst, iavail);
endinterface

// File: rtl/sa_inst_issue.sv
// rtl/sa_inst_issue.sv - flow-controlled instruction issue queue feeding vinst_ctl
// Optional zero-latency empty-queue bypass enabled by defining LAP_ISSUE_BYPASS_EN.
module sa_inst_issue
  import sa_inst_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  sa_inst_issue_if.slave    io,
  output logic [LW-1:0]     level,
  output logic [31:0]       icount
);

  sa_inst_t      mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [LW-1:0] cnt;

  logic byp;
  logic push;
  logic pop;
  logic pop_mem;

`ifdef LAP_ISSUE_BYPASS_EN
  assign byp = (cnt == '0) && io.hvalid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign io.hready = !flush && (cnt != LW'(DEPTH));

  always_comb begin
    io.iavail = (cnt != '0);
    io.inst   = mem[rp];
    if (byp) begin
      io.iavail = 1'b1;
      io.inst   = io.hinst;
    end
  end

  // A bypassed word that is taken immediately never touches the array
  assign push    = io.hvalid && io.hready && !(byp && io.ird);
  assign pop     = io.iavail && io.ird && !flush;
  assign pop_mem = pop && !byp;

  assign level = cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= io.hinst;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      icount <= '0;
    end else if (flush) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      icount <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop_mem) begin
        rp <= rp + 1'b1;
      end
      if (pop) begin
        icount <= icount + 32'd1;
      end
      if (push && !pop_mem) begin
        cnt <= cnt + 1'b1;
      end else if (pop_mem && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sa_inst_issue.sv
// tb/tb_sa_inst_issue.sv - scoreboard testbench for sa_inst_issue
module tb_sa_inst_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  level;
  logic [31:0] icount;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  sa_inst_issue_if io();

  sa_inst_issue #(.DEPTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .io     (io),
    .level  (level),
    .icount (icount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue monitor: the handshake seen mid-cycle completes on the following rising edge
  always @(negedge clk) begin
    if (reset && !flush && io.iavail && io.ird) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", io.inst, 32'hFFFF_FFFF);
      end else begin
        check("issue_order", io.inst, exp_q.pop_front());
      end
    end
  end

  initial begin
    io.hvalid = 1'b0;
    io.hinst  = '0;
    io.ird    = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();

    check("reset_iavail", {31'd0, io.iavail}, 32'd0);
    check("reset_level",  {28'd0, level},     32'd0);
    check("reset_hready", {31'd0, io.hready}, 32'd1);
    check("reset_icount", icount,             32'd0);

    io.ird = 1'b1;
    repeat (5) step();
    io.ird = 1'b0;
    check("idle_level",  {28'd0, level},     32'd0);
    check("idle_icount", icount,             32'd0);
    check("idle_iavail", {31'd0, io.iavail}, 32'd0);

    // Fill to capacity, then offer a ninth word
    for (int i = 1; i <= 8; i++) begin
      io.hvalid = 1'b1;
      io.hinst  = 32'(i);
      exp_q.push_back(32'(i));
      step();
    end
    io.hinst = 32'd9;
    #1;
    check("full_level",  {28'd0, level},     32'd8);
    check("full_hready", {31'd0, io.hready}, 32'd0);
    step();
    io.hvalid = 1'b0;
    check("ninth_ignored", {28'd0, level}, 32'd8);

    io.ird = 1'b1;
    repeat (8) step();
    io.ird = 1'b0;
    check("drain_icount", icount,             32'd8);
    check("drain_iavail", {31'd0, io.iavail}, 32'd0);
    check("drain_level",  {28'd0, level},     32'd0);

    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_icount", icount, 32'd0);

    // Streaming at constant occupancy of 3, wrapping the pointers
    for (int k = 0; k < 3; k++) begin
      io.hvalid = 1'b1;
      io.hinst  = 32'h100 + 32'(k);
      exp_q.push_back(32'h100 + 32'(k));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      io.hvalid = 1'b1;
      io.ird    = 1'b1;
      io.hinst  = 32'h103 + 32'(k);
      exp_q.push_back(32'h103 + 32'(k));
      step();
      check("stream_level", {28'd0, level}, 32'd3);
    end
    io.ird = 1'b0;
    check("stream_icount", icount, 32'd20);

    for (int k = 0; k < 5; k++) begin
      io.hinst = 32'h200 + 32'(k);
      exp_q.push_back(32'h200 + 32'(k));
      step();
    end
    check("refill_level", {28'd0, level}, 32'd8);

    // Full with simultaneous pop: no lookahead, push rejected
    io.hinst = 32'h300;
    io.ird   = 1'b1;
    step();
    check("full_pop_level", {28'd0, level}, 32'd7);
    io.hinst = 32'h301;
    exp_q.push_back(32'h301);
    step();
    check("push_pop_level", {28'd0, level}, 32'd7);
    io.hvalid = 1'b0;
    repeat (2) step();
    io.ird = 1'b0;
    check("pre_flush_level", {28'd0, level}, 32'd5);

    // Flush beats a concurrent push and pop
    flush     = 1'b1;
    io.hvalid = 1'b1;
    io.hinst  = 32'hDEAD;
    io.ird    = 1'b1;
    #1;
    check("flush_hready", {31'd0, io.hready}, 32'd0);
    step();
    flush     = 1'b0;
    io.hvalid = 1'b0;
    io.ird    = 1'b0;
    exp_q.delete();
    check("flush_level",  {28'd0, level},     32'd0);
    check("flush_icnt",   icount,             32'd0);
    check("flush_iavail", {31'd0, io.iavail}, 32'd0);

    // Asynchronous reset between edges
    for (int k = 0; k < 4; k++) begin
      io.hvalid = 1'b1;
      io.hinst  = 32'h400 + 32'(k);
      exp_q.push_back(32'h400 + 32'(k));
      step();
    end
    io.hvalid = 1'b0;
    check("pre_reset_level", {28'd0, level}, 32'd4);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("async_iavail", {31'd0, io.iavail}, 32'd0);
    check("async_level",  {28'd0, level},     32'd0);
    check("async_hready", {31'd0, io.hready}, 32'd1);
    step();
    reset = 1'b1;
    step();

    io.hvalid = 1'b1;
    io.hinst  = 32'h5;
    io.ird    = 1'b1;
    exp_q.push_back(32'h5);
`ifdef LAP_ISSUE_BYPASS_EN
    #1;
    check("bypass_iavail", {31'd0, io.iavail}, 32'd1);
    check("bypass_inst",   io.inst,            32'h5);
    step();
    io.hvalid = 1'b0;
    io.ird    = 1'b0;
    check("bypass_icount", icount,         32'd1);
    check("bypass_level",  {28'd0, level}, 32'd0);
`else
    #1;
    check("nobypass_iavail", {31'd0, io.iavail}, 32'd0);
    step();
    io.hvalid = 1'b0;
    check("nobypass_level",  {28'd0, level},     32'd1);
    check("nobypass_icount", icount,             32'd0);
    step();
    io.ird = 1'b0;
    check("nobypass_issued", icount, 32'd1);
`endif
    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
